// File: rtl/memory_access_stage_pkg.sv
// Shared processor definitions used by the memory access stage.
//   DATA_WIDTH / REG_ADDR_WIDTH : default datapath and register-index widths
//   state_t                     : memory-stage FSM encoding (IDLE=0, ACCESS=1)
//   ALU_*                       : ALU opcode constants shared across the pipeline
//   word_aligned()              : true when the two low address bits are zero
package memory_access_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [2:0] ALU_Add = 3'd0;
  localparam logic [2:0] ALU_Sub = 3'd1;
  localparam logic [2:0] ALU_And = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_SLR = 3'd4;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/memory_access_stage_access_timer.sv
// Wait counter for an outstanding data-memory access.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : force the count back to zero
//   enable       : advance the count by one this cycle
//   expired      : count has reached TIMEOUT_CYCLES-1 (last allowed cycle)
module memory_access_stage_access_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal value so a non-power-of-two limit never wraps.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage, directly downstream of the ALU.
// ALU results either pass straight through to writeback or are used as a
// word address for a load/store over a req/ack data-memory bus. Upstream is
// stalled while an access is outstanding; every instruction retires with a
// single-cycle out_valid pulse, qualified by err on misalignment, illegal
// read+write encoding, or bus timeout.
//   clock, reset                       : clock, synchronous active-high reset
//   in_valid, alu_result, store_data,
//   sig_mem_read, sig_mem_write, rd_in : upstream instruction
//   stall                              : combinational hold request to upstream
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack      : data-memory bus
//   out_valid, wb_data, rd_out, err    : writeback result
module memory_access_stage #(
  parameter int DATA_WIDTH     = memory_access_stage_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = memory_access_stage_pkg::REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic                      sig_mem_read,
  input  logic                      sig_mem_write,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      err
);

  import memory_access_stage_pkg::*;

  state_t                    state;
  logic [REG_ADDR_WIDTH-1:0] rd_hold;
  logic                      mem_op;
  logic                      illegal;
  logic                      misaligned;
  logic                      start_access;
  logic                      timer_expired;

  always_comb begin
    mem_op       = sig_mem_read || sig_mem_write;
    illegal      = sig_mem_read && sig_mem_write;
    misaligned   = !word_aligned(alu_result[1:0]);
    start_access = (state == IDLE) && in_valid && mem_op && !illegal && !misaligned;
    // In ACCESS the instruction is consumed in the cycle that ends the access
    // (ack or final timeout cycle), so stall drops exactly then.
    stall        = start_access ||
                   ((state == ACCESS) && !mem_ack && !timer_expired);
  end

  memory_access_stage_access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (state == ACCESS),
    .expired(timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      wb_data   <= '0;
      rd_out    <= '0;
      rd_hold   <= '0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              out_valid <= 1'b1;
              wb_data   <= alu_result;
              rd_out    <= rd_in;
            end else if (illegal || misaligned) begin
              out_valid <= 1'b1;
              err       <= 1'b1;
              wb_data   <= '0;
              rd_out    <= rd_in;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= sig_mem_write;
              mem_addr  <= alu_result;
              mem_wdata <= store_data;
              rd_hold   <= rd_in;
            end
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            wb_data   <= mem_we ? '0 : mem_rdata;
            rd_out    <= rd_hold;
          end else if (timer_expired) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            err       <= 1'b1;
            wb_data   <= '0;
            rd_out    <= rd_hold;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: a driver issues directed and
// random instructions and pushes the expected writeback into a queue; an
// independent monitor pops and compares on every out_valid pulse.
module tb_memory_access_stage;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        sig_mem_read;
  logic        sig_mem_write;
  logic [3:0]  rd_in;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] wb_data;
  logic [3:0]  rd_out;
  logic        err;

  always #5 clock = ~clock;

  memory_access_stage #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .sig_mem_read (sig_mem_read),
    .sig_mem_write(sig_mem_write),
    .rd_in        (rd_in),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .out_valid    (out_valid),
    .wb_data      (wb_data),
    .rd_out       (rd_out),
    .err          (err)
  );

  // Behavioural data memory: acks after ack_delay cycles of mem_req.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          age;
  int          ack_delay;
  logic        inject_ack;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ack   = (mem_req && (age == ack_delay)) || inject_ack;

  always @(posedge clock) begin
    if (!mem_req || mem_ack) age <= 0;
    else                     age <= age + 1;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 wb_data=0x%08h expected no output at %0t",
                 wb_data, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = read+write (illegal).
  // Called just after a rising edge; returns just after the consuming edge.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] sd,
                       input logic [3:0] r, input int dly);
    exp_t e;
    int   stalls;
    int   exp_stalls;
    bit   done;
    bit   rdf, wrf, is_mem, ok;
    rdf    = (kind == 1) || (kind == 3);
    wrf    = (kind == 2) || (kind == 3);
    is_mem = ((kind == 1) || (kind == 2)) && (a[1:0] == 2'b00);
    ack_delay     = dly;
    in_valid      = 1'b1;
    alu_result    = a;
    store_data    = sd;
    sig_mem_read  = rdf;
    sig_mem_write = wrf;
    rd_in         = r;

    e.rd = r;
    if (!is_mem) begin
      e.err      = (kind != 0);
      e.data     = (kind == 0) ? a : 32'h0;
      exp_stalls = 0;
    end else begin
      ok         = dly < TIMEOUT;
      e.err      = !ok;
      e.data     = (ok && kind == 1) ? ref_mem[a[9:2]] : 32'h0;
      if (ok && kind == 2) ref_mem[a[9:2]] = sd;
      exp_stalls = 1 + ((dly < TIMEOUT - 1) ? dly : TIMEOUT - 1);
    end

    stalls = 0;
    done   = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      if (is_mem && c > 0) begin
        chk("mem_req_held", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, a);
        chk("mem_we", 32'(mem_we), 32'(wrf));
        if (wrf) chk("mem_wdata", mem_wdata, sd);
      end
      if (!stall) done = 1;
      else        stalls++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_bound: got stall still high after 64 cycles expected release");
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (!is_mem) chk("no_mem_req", 32'(mem_req), 32'd0);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    in_valid      = 1'b0;
    sig_mem_read  = 1'b0;
    sig_mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int          kind;
    int          dly;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem[i]     = v;
      ref_mem[i] = v;
    end
    reset         = 1'b1;
    in_valid      = 1'b0;
    alu_result    = '0;
    store_data    = '0;
    sig_mem_read  = 1'b0;
    sig_mem_write = 1'b0;
    rd_in         = '0;
    inject_ack    = 1'b0;
    ack_delay     = 0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed cases.
    issue(0, 32'd30, 32'd0, 4'd3, 0);
    mem[32'h40 >> 2]     = 32'hDEADBEEF;
    ref_mem[32'h40 >> 2] = 32'hDEADBEEF;
    issue(1, 32'h40, 32'd0, 4'd5, 3);
    issue(2, 32'h80, 32'h0000_0F0F, 4'd6, 0);
    chk("store_written", mem[32'h80 >> 2], 32'h0000_0F0F);
    issue(1, 32'h42, 32'd0, 4'd7, 0);
    issue(3, 32'h40, 32'd0, 4'd8, 0);
    issue(1, 32'h44, 32'd0, 4'd9, 1000);
    issue(0, 32'h1234, 32'd0, 4'd10, 0);
    issue(1, 32'h48, 32'd0, 4'd11, TIMEOUT - 1);
    issue(2, 32'h4C, 32'hCAFE_F00D, 4'd12, TIMEOUT);
    chk("timeout_no_write", mem[32'h4C >> 2], ref_mem[32'h4C >> 2]);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a    = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) dly = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
      else                           dly = $urandom_range(0, 4);
      issue(kind, a, $urandom, 4'($urandom_range(0, 15)), dly);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end

    // Reset during an outstanding load; a later stray ack must be ignored.
    ack_delay     = 1000;
    in_valid      = 1'b1;
    alu_result    = 32'h50;
    sig_mem_read  = 1'b1;
    sig_mem_write = 1'b0;
    rd_in         = 4'd13;
    @(negedge clock);
    chk("mid_rst_stall", 32'(stall), 32'd1);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("mid_rst_req_before", 32'(mem_req), 32'd1);
    reset         = 1'b1;
    in_valid      = 1'b0;
    sig_mem_read  = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_req_dropped", 32'(mem_req), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    reset      = 1'b0;
    inject_ack = 1'b1;
    @(negedge clock);
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    inject_ack = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("late_ack_no_out", 32'(out_valid), 32'd0);
      chk("late_ack_no_req", 32'(mem_req), 32'd0);
    end
    @(posedge clock);
    #1;
    issue(0, 32'h5A5A, 32'd0, 4'd14, 0);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
